l2_cache_responder: RTL and testbench

//  Responder end of the arbiter->L2 line interface: accepts one line-granular read/write at a time

---
 rtl/lc3b_types.sv | 16 +
 rtl/l2_cache_responder_if.sv | 35 +++
 rtl/l2_array.sv | 52 +++++
 rtl/l2_cache_responder.sv | 130 +++++++++++++
 tb/tb_l2_cache_responder.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/lc3b_types.sv
// Shared LC-3b types plus the L2 responder FSM encoding and line-offset constant.
package lc3b_types;

    typedef logic [15:0]  lc3b_word;
    typedef logic [127:0] cache_line;

    typedef enum logic [1:0] {
        IDLE,
        WRITEBACK,
        FILL,
        RESP
    } l2_state_t;

    localparam int unsigned L2_OFFSET_BITS = 4;

endpackage

// File: rtl/l2_cache_responder_if.sv
// Arbiter->L2 line request channel and L2->physical-memory line port, bundled together.
interface l2_cache_responder_if;
    import lc3b_types::*;

    logic      arbiter_mem_read;
    logic      arbiter_mem_write;
    lc3b_word  arbiter_mem_address;
    cache_line arbiter_mem_wdata;
    logic      l2_mem_resp;
    cache_line l2_mem_rdata;

    logic      pmem_read;
    logic      pmem_write;
    lc3b_word  pmem_address;
    cache_line pmem_wdata;
    cache_line pmem_rdata;
    logic      pmem_resp;

    // The L2 responder's view.
    modport slave (
        input  arbiter_mem_read, arbiter_mem_write, arbiter_mem_address, arbiter_mem_wdata,
        output l2_mem_resp, l2_mem_rdata,
        output pmem_read, pmem_write, pmem_address, pmem_wdata,
        input  pmem_rdata, pmem_resp
    );

    // The surrounding arbiter and physical memory.
    modport master (
        output arbiter_mem_read, arbiter_mem_write, arbiter_mem_address, arbiter_mem_wdata,
        input  l2_mem_resp, l2_mem_rdata,
        input  pmem_read, pmem_write, pmem_address, pmem_wdata,
        output pmem_rdata, pmem_resp
    );

endinterface

// File: rtl/l2_array.sv
// Direct-mapped L2 storage: valid/dirty (reset), tag/data (not reset); async read, sync write.
module l2_array
    import lc3b_types::*;
#(
    parameter int unsigned SET_BITS = 3,
    parameter int unsigned TAG_BITS = 16 - L2_OFFSET_BITS - SET_BITS
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [SET_BITS-1:0] index,
    output logic                rd_valid,
    output logic                rd_dirty,
    output logic [TAG_BITS-1:0] rd_tag,
    output cache_line           rd_data,
    input  logic                we_valid,
    input  logic                we_dirty,
    input  logic                we_tag,
    input  logic                we_data,
    input  logic                wr_valid,
    input  logic                wr_dirty,
    input  logic [TAG_BITS-1:0] wr_tag,
    input  cache_line           wr_data
);

    localparam int unsigned SETS = 1 << SET_BITS;

    logic [SETS-1:0]     valid_bits;
    logic [SETS-1:0]     dirty_bits;
    logic [TAG_BITS-1:0] tag_mem  [SETS];
    cache_line           data_mem [SETS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_bits <= '0;
            dirty_bits <= '0;
        end else begin
            if (we_valid) valid_bits[index] <= wr_valid;
            if (we_dirty) dirty_bits[index] <= wr_dirty;
        end
    end

    always_ff @(posedge clk) begin
        if (we_tag)  tag_mem[index]  <= wr_tag;
        if (we_data) data_mem[index] <= wr_data;
    end

    assign rd_valid = valid_bits[index];
    assign rd_dirty = dirty_bits[index];
    assign rd_tag   = tag_mem[index];
    assign rd_data  = data_mem[index];

endmodule

// File: rtl/l2_cache_responder.sv
// Direct-mapped write-back, write-allocate L2: one outstanding line request from the arbiter,
// misses serviced through the pmem line port with at most one victim write-back.
module l2_cache_responder
    import lc3b_types::*;
#(
    parameter int unsigned SET_BITS = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    l2_cache_responder_if.slave  bus
);

    localparam int unsigned TAG_BITS = 16 - L2_OFFSET_BITS - SET_BITS;

    l2_state_t                 state;
    logic [SET_BITS-1:0]       index;
    logic [TAG_BITS-1:0]       tag;
    logic [L2_OFFSET_BITS-1:0] unused_offset;
    logic                      req_rd;
    logic                      req_wr;
    logic                      hit;

    logic                      arr_valid;
    logic                      arr_dirty;
    logic [TAG_BITS-1:0]       arr_tag;
    cache_line                 arr_data;
    logic                      fill_we;
    logic                      store_we;
    logic                      arr_we;
    cache_line                 arr_wdata;

    assign index         = bus.arbiter_mem_address[L2_OFFSET_BITS +: SET_BITS];
    assign tag           = bus.arbiter_mem_address[15 -: TAG_BITS];
    assign unused_offset = bus.arbiter_mem_address[L2_OFFSET_BITS-1:0];

    // Read wins when both strobes are high; the write is dropped.
    assign req_rd = bus.arbiter_mem_read;
    assign req_wr = bus.arbiter_mem_write & ~bus.arbiter_mem_read;
    assign hit    = arr_valid && (arr_tag == tag);

    always_comb begin
        fill_we   = (state == FILL) && bus.pmem_resp;
        store_we  = (state == RESP) && req_wr;
        arr_we    = fill_we | store_we;
        arr_wdata = fill_we ? bus.pmem_rdata : bus.arbiter_mem_wdata;
    end

    l2_array #(
        .SET_BITS (SET_BITS),
        .TAG_BITS (TAG_BITS)
    ) u_array (
        .clk      (clk),
        .rst_n    (rst_n),
        .index    (index),
        .rd_valid (arr_valid),
        .rd_dirty (arr_dirty),
        .rd_tag   (arr_tag),
        .rd_data  (arr_data),
        .we_valid (arr_we),
        .we_dirty (arr_we),
        .we_tag   (arr_we),
        .we_data  (arr_we),
        .wr_valid (1'b1),
        .wr_dirty (store_we),
        .wr_tag   (tag),
        .wr_data  (arr_wdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= IDLE;
            bus.l2_mem_resp  <= 1'b0;
            bus.l2_mem_rdata <= '0;
            bus.pmem_read    <= 1'b0;
            bus.pmem_write   <= 1'b0;
            bus.pmem_address <= '0;
            bus.pmem_wdata   <= '0;
        end else begin
            bus.l2_mem_resp <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (req_rd || req_wr) begin
                        if (hit) begin
                            state           <= RESP;
                            bus.l2_mem_resp <= 1'b1;
                            if (req_rd) bus.l2_mem_rdata <= arr_data;
                        end else if (arr_valid && arr_dirty) begin
                            state            <= WRITEBACK;
                            bus.pmem_write   <= 1'b1;
                            bus.pmem_address <= {arr_tag, index, {L2_OFFSET_BITS{1'b0}}};
                            bus.pmem_wdata   <= arr_data;
                        end else if (req_rd) begin
                            state            <= FILL;
                            bus.pmem_read    <= 1'b1;
                            bus.pmem_address <= {tag, index, {L2_OFFSET_BITS{1'b0}}};
                        end else begin
                            // Whole-line write allocates without fetching.
                            state           <= RESP;
                            bus.l2_mem_resp <= 1'b1;
                        end
                    end
                end
                WRITEBACK: begin
                    if (bus.pmem_resp) begin
                        bus.pmem_write <= 1'b0;
                        if (req_rd) begin
                            state            <= FILL;
                            bus.pmem_read    <= 1'b1;
                            bus.pmem_address <= {tag, index, {L2_OFFSET_BITS{1'b0}}};
                        end else begin
                            state           <= RESP;
                            bus.l2_mem_resp <= 1'b1;
                        end
                    end
                end
                FILL: begin
                    if (bus.pmem_resp) begin
                        state            <= RESP;
                        bus.pmem_read    <= 1'b0;
                        bus.l2_mem_resp  <= 1'b1;
                        bus.l2_mem_rdata <= bus.pmem_rdata;
                    end
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_l2_cache_responder.sv
// Directed bench for l2_cache_responder with a fixed-latency physical-memory model.
module tb_l2_cache_responder;
    import lc3b_types::*;

    localparam int PMEM_LAT = 3;
    localparam int LAT_HIT  = 1;
    localparam int LAT_MISS = 1 + PMEM_LAT;
    localparam int LAT_WB   = 2 * (1 + PMEM_LAT);

    logic clk;
    logic rst_n;

    l2_cache_responder_if bus ();

    l2_cache_responder #(
        .SET_BITS (3)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int        errors = 0;
    int        checks = 0;
    int        pmem_reads = 0;
    int        pmem_writes = 0;
    int        both_high = 0;
    lc3b_word  last_rd_addr;
    lc3b_word  last_wr_addr;
    cache_line last_wr_data;
    cache_line mem [lc3b_word];

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic cache_line pat(input lc3b_word a);
        return {8{a ^ 16'h5A5A}};
    endfunction

    function automatic cache_line mem_line(input lc3b_word a);
        lc3b_word k = a & 16'hFFF0;
        if (mem.exists(k)) return mem[k];
        return pat(k);
    endfunction

    // Physical memory: answers any held request PMEM_LAT negedges after first seeing it.
    initial begin
        int cnt = 0;
        bus.pmem_resp  = 1'b0;
        bus.pmem_rdata = '0;
        forever begin
            @(negedge clk);
            if (bus.pmem_read && bus.pmem_write) both_high++;
            if (!rst_n) begin
                cnt = 0;
                bus.pmem_resp = 1'b0;
            end else if (bus.pmem_resp) begin
                bus.pmem_resp = 1'b0;
                cnt = 0;
            end else if (bus.pmem_read || bus.pmem_write) begin
                cnt++;
                if (cnt == PMEM_LAT) begin
                    bus.pmem_resp = 1'b1;
                    if (bus.pmem_write) begin
                        pmem_writes++;
                        last_wr_addr = bus.pmem_address;
                        last_wr_data = bus.pmem_wdata;
                        mem[bus.pmem_address] = bus.pmem_wdata;
                    end else begin
                        pmem_reads++;
                        last_rd_addr = bus.pmem_address;
                        bus.pmem_rdata = mem_line(bus.pmem_address);
                    end
                end
            end
        end
    end

    task automatic request(input logic rd, input logic wr, input lc3b_word addr,
                           input cache_line wdata, output cache_line rdata, output int lat);
        @(negedge clk);
        bus.arbiter_mem_read    = rd;
        bus.arbiter_mem_write   = wr;
        bus.arbiter_mem_address = addr;
        bus.arbiter_mem_wdata   = wdata;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!bus.l2_mem_resp && lat < 40);
        if (!bus.l2_mem_resp) check("resp_timeout", 1'b0, 1'b1);
        rdata = bus.l2_mem_rdata;
        @(negedge clk);
        check("resp_one_cycle", bus.l2_mem_resp, 1'b0);
        bus.arbiter_mem_read  = 1'b0;
        bus.arbiter_mem_write = 1'b0;
    endtask

    initial begin
        cache_line rd;
        int        lat;
        int        rds;
        int        wrs;
        int        n;
        int        resp_seen;
        cache_line l1 = {8{16'h1111}};
        cache_line l2 = {8{16'h2222}};
        cache_line l3 = {8{16'h3333}};

        rst_n = 1'b0;
        bus.arbiter_mem_read    = 1'b0;
        bus.arbiter_mem_write   = 1'b0;
        bus.arbiter_mem_address = '0;
        bus.arbiter_mem_wdata   = '0;
        repeat (3) @(negedge clk);
        check("rst_resp",  bus.l2_mem_resp,  1'b0);
        check("rst_rdata", bus.l2_mem_rdata, '0);
        check("rst_pread", bus.pmem_read,    1'b0);
        check("rst_pwrite", bus.pmem_write,  1'b0);
        check("rst_paddr", bus.pmem_address, '0);
        check("rst_pwdata", bus.pmem_wdata,  '0);
        rst_n = 1'b1;

        // Cold read miss.
        request(1'b1, 1'b0, 16'h1230, '0, rd, lat);
        check("cold_rdata", rd, pat(16'h1230));
        check("cold_lat", lat, LAT_MISS);
        check("cold_reads", pmem_reads, 1);
        check("cold_raddr", last_rd_addr, 16'h1230);
        check("cold_writes", pmem_writes, 0);

        // Hit with a different offset in the same line.
        request(1'b1, 1'b0, 16'h1238, '0, rd, lat);
        check("hit_rdata", rd, pat(16'h1230));
        check("hit_lat", lat, LAT_HIT);
        check("hit_reads", pmem_reads, 1);

        // Write hit, then dirty read hit.
        request(1'b0, 1'b1, 16'h1230, l1, rd, lat);
        check("whit_lat", lat, LAT_HIT);
        request(1'b1, 1'b0, 16'h1230, '0, rd, lat);
        check("dirty_rdata", rd, l1);
        check("dirty_lat", lat, LAT_HIT);
        check("whit_pmem", pmem_reads + pmem_writes, 1);

        // Conflict miss on the same set evicts the dirty line first.
        request(1'b1, 1'b0, 16'h1A30, '0, rd, lat);
        check("evict_lat", lat, LAT_WB);
        check("evict_writes", pmem_writes, 1);
        check("evict_waddr", last_wr_addr, 16'h1230);
        check("evict_wdata", last_wr_data, l1);
        check("evict_raddr", last_rd_addr, 16'h1A30);
        check("evict_rdata", rd, pat(16'h1A30));

        // Victim is clean now; the written-back data comes back from pmem.
        request(1'b1, 1'b0, 16'h1230, '0, rd, lat);
        check("refetch_lat", lat, LAT_MISS);
        check("refetch_rdata", rd, l1);
        check("refetch_writes", pmem_writes, 1);

        // Read and write together: read wins, line stays clean.
        request(1'b1, 1'b1, 16'h0040, l2, rd, lat);
        check("rw_rdata", rd, pat(16'h0040));
        check("rw_lat", lat, LAT_MISS);
        request(1'b1, 1'b0, 16'h0040, '0, rd, lat);
        check("rw_reread", rd, pat(16'h0040));
        check("rw_hit_lat", lat, LAT_HIT);
        wrs = pmem_writes;
        request(1'b1, 1'b0, 16'h0840, '0, rd, lat);
        check("rw_clean_lat", lat, LAT_MISS);
        check("rw_clean_wb", pmem_writes, wrs);

        // Write miss into an empty set allocates with no pmem traffic.
        rds = pmem_reads;
        request(1'b0, 1'b1, 16'h2050, l3, rd, lat);
        check("wmiss_lat", lat, LAT_HIT);
        check("wmiss_pmem", pmem_reads + pmem_writes, rds + wrs);
        request(1'b1, 1'b0, 16'h2050, '0, rd, lat);
        check("wmiss_rdata", rd, l3);

        // Reset while a fill is outstanding.
        @(negedge clk);
        bus.arbiter_mem_read    = 1'b1;
        bus.arbiter_mem_address = 16'h3000;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.pmem_read && n < 20);
        check("rst_fill_started", bus.pmem_read, 1'b1);
        rst_n = 1'b0;
        #1;
        check("rst_drop_pread", bus.pmem_read, 1'b0);
        resp_seen = 0;
        repeat (4) begin
            @(negedge clk);
            if (bus.l2_mem_resp) resp_seen++;
        end
        bus.arbiter_mem_read = 1'b0;
        check("rst_no_resp", resp_seen, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Everything misses after reset; the unflushed dirty line is gone.
        wrs = pmem_writes;
        request(1'b1, 1'b0, 16'h2050, '0, rd, lat);
        check("post_rst_lat", lat, LAT_MISS);
        check("post_rst_rdata", rd, pat(16'h2050));
        check("post_rst_wb", pmem_writes, wrs);
        request(1'b1, 1'b0, 16'h1238, '0, rd, lat);
        check("post_rst_lat2", lat, LAT_MISS);
        check("post_rst_rdata2", rd, l1);

        check("never_both", both_high, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
